// File: rtl/alias_field_pkg.sv
// rtl/alias_field_pkg.sv - field widths, packed field struct, mask positions and arbiter states
package alias_field_pkg;

  localparam int F9_W     = 9;
  localparam int F4_W     = 4;
  localparam int F1_W     = 1;
  localparam int FIELDS_W = 14;

  localparam int MASK_F9 = 2;
  localparam int MASK_F4 = 1;
  localparam int MASK_F1 = 0;

  typedef struct packed {
    logic [F9_W-1:0] f9;
    logic [F4_W-1:0] f4;
    logic [F1_W-1:0] f1;
  } fields_t;

  typedef enum logic {IDLE, OWN} state_t;

  // Fields whose mask bit is clear keep their committed value.
  function automatic fields_t merge_fields(fields_t cur, fields_t wr, logic [2:0] mask);
    fields_t r;
    r    = cur;
    if (mask[MASK_F9]) r.f9 = wr.f9;
    if (mask[MASK_F4]) r.f4 = wr.f4;
    if (mask[MASK_F1]) r.f1 = wr.f1;
    return r;
  endfunction

endpackage

// File: rtl/alias_field_arb_rr_pick.sv
// rtl/alias_field_arb_rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int               s;
  logic [PTR_W-1:0] c;

  // Search starts at ptr and wraps modulo NREQ, so non-power-of-two NREQ never yields an out-of-range index.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = 0;
    c   = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      c = PTR_W'(s);
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alias_field_arb.sv
// rtl/alias_field_arb.sv - round-robin arbiter sharing one aliased field register, with burst lock
module alias_field_arb
  import alias_field_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_mask,
  input  logic [14*NREQ-1:0]     req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [FIELDS_W-1:0]    fields,
  output logic [127:0]           out,
  output logic                   upd_valid,
  output logic [PTR_W-1:0]       upd_src,
  output logic                   busy
);

  state_t           state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  fields_t          fields_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic [NREQ-1:0]  own_onehot;
  logic             xfer;
  logic [PTR_W-1:0] xidx;
  logic [PTR_W-1:0] next_ptr;
  logic [2:0]       sel_mask;
  fields_t          sel_data;
  logic             sel_last;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_onehot = NREQ'(1) << owner;
  assign xidx       = (state == IDLE) ? pick_idx : owner;
  assign xfer       = rst_n && ((state == IDLE) ? pick_any : req_valid[owner]);
  assign next_ptr   = (xidx == PTR_W'(NREQ - 1)) ? '0 : xidx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (state == IDLE) req_ready = pick_gnt;
      else               req_ready = req_valid & own_onehot;
    end
  end

  always_comb begin
    sel_mask = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == xidx) begin
        sel_mask = req_mask[3*i +: 3];
        sel_data = req_data[14*i +: 14];
        sel_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      fields_q  <= '0;
      upd_valid <= 1'b0;
      upd_src   <= '0;
    end else begin
      upd_valid <= xfer;
      if (xfer) begin
        upd_src  <= xidx;
        fields_q <= merge_fields(fields_q, sel_data, sel_mask);
        if (sel_last) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state <= OWN;
          owner <= xidx;
        end
      end
    end
  end

  assign fields = fields_q;
  assign out    = {100'b0, fields_q, fields_q};
  assign busy   = (state == OWN);

endmodule
